// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and defaults for the two-master Wishbone arbiter
package wb_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Index of a master: 0 = CPU side, 1 = DMA/blitter
   typedef logic owner_t;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/wb_timeout_watchdog.sv
// rtl/wb_timeout_watchdog.sv - stalled-strobe watchdog, flags the TIMEOUT_CYCLES-th unacked strobe cycle
module wb_timeout_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic stb_i,
   input  logic ack_i,
   input  logic clr_i,
   output logic expire_o
);

   // A zero timeout still needs a legal one-bit counter; expire is then tied off
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

   logic [CNT_W-1:0] count_q, count_d;

   // count_q holds the stalled cycles already seen, so the current stalled cycle is number count_q+1
   always_comb begin
      expire_o = WD_EN & stb_i & ~ack_i & (count_q == CNT_LAST);
      count_d  = count_q;
      if (clr_i | ack_i | ~stb_i) begin
         count_d = '0;
      end else if (count_q != CNT_MAX) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register, saturating rather than wrapping
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// rtl/wishbone_arbiter_2m.sv - two-master round-robin Wishbone arbiter with stall watchdog
module wishbone_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                m0_cyc_i,
   input  logic                m0_stb_i,
   input  logic                m0_we_i,
   input  logic [DATA_W/8-1:0] m0_sel_i,
   input  logic [ADDR_W-1:0]   m0_adr_i,
   input  logic [DATA_W-1:0]   m0_dat_i,
   output logic [DATA_W-1:0]   m0_dat_o,
   output logic                m0_ack_o,
   output logic                m0_err_o,
   input  logic                m1_cyc_i,
   input  logic                m1_stb_i,
   input  logic                m1_we_i,
   input  logic [DATA_W/8-1:0] m1_sel_i,
   input  logic [ADDR_W-1:0]   m1_adr_i,
   input  logic [DATA_W-1:0]   m1_dat_i,
   output logic [DATA_W-1:0]   m1_dat_o,
   output logic                m1_ack_o,
   output logic                m1_err_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [DATA_W/8-1:0] s_sel_o,
   output logic [ADDR_W-1:0]   s_adr_o,
   output logic [DATA_W-1:0]   s_dat_o,
   input  logic [DATA_W-1:0]   s_dat_i,
   input  logic                s_ack_i,
   output logic [1:0]          grant_o
);

   localparam int SEL_W = DATA_W / 8;

   arb_state_t state_q, state_d;
   owner_t     owner_q, owner_d;
   owner_t     last_grant_q, last_grant_d;
   owner_t     winner;

   logic              busy;
   logic              own_cyc;
   logic              own_stb;
   logic              own_we;
   logic [SEL_W-1:0]  own_sel;
   logic [ADDR_W-1:0] own_adr;
   logic [DATA_W-1:0] own_dat;
   logic              bus_stb;
   logic              expire;

   // Select the current owner's request signals
   always_comb begin
      busy    = (state_q == BUSY);
      own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
      own_stb = owner_q ? m1_stb_i : m0_stb_i;
      own_we  = owner_q ? m1_we_i  : m0_we_i;
      own_sel = owner_q ? m1_sel_i : m0_sel_i;
      own_adr = owner_q ? m1_adr_i : m0_adr_i;
      own_dat = owner_q ? m1_dat_i : m0_dat_i;
      bus_stb = busy & own_cyc & own_stb;
   end

   // Watchdog sees the strobe before the abort gating, otherwise expire would feed back on itself
   wb_timeout_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .stb_i   (bus_stb),
      .ack_i   (s_ack_i),
      .clr_i   (~busy),
      .expire_o(expire)
   );

   // Shared-bus and per-master outputs, all derived from the registered owner so reset clears them at once
   always_comb begin
      s_cyc_o  = busy & own_cyc & ~expire;
      s_stb_o  = bus_stb & ~expire;
      s_we_o   = busy & own_we;
      s_sel_o  = busy ? own_sel : '0;
      s_adr_o  = busy ? own_adr : '0;
      s_dat_o  = busy ? own_dat : '0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      m0_ack_o = s_ack_i & busy & ~owner_q;
      m1_ack_o = s_ack_i & busy & owner_q;
      m0_err_o = expire & ~owner_q;
      m1_err_o = expire & owner_q;
      grant_o  = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   end

   // Arbitration: grant in IDLE, hold while owner keeps cyc, drop to IDLE on release or abort
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      winner       = (m0_cyc_i & m1_cyc_i) ? ~last_grant_q : m1_cyc_i;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i | m1_cyc_i) begin
               state_d      = BUSY;
               owner_d      = winner;
               last_grant_d = winner;
            end
         end
         BUSY: begin
            if (~own_cyc | expire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state registers; last_grant resets to master 1 so master 0 wins the first tie
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// tb/tb_wishbone_arbiter_2m.sv - scoreboard bench for wishbone_arbiter_2m
module tb_wishbone_arbiter_2m;

   localparam logic [15:0] STALL_ADR = 16'h0100;
   localparam int K_GNT = 0;
   localparam int K_ACK = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      int          c;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [3:0]  m0_sel, m1_sel, s_sel_o;
   logic [15:0] m0_adr, m1_adr, s_adr_o;
   logic [31:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
   logic [1:0]  grant_o;
   logic        force_ack;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   wishbone_arbiter_2m #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] wdat(input int n, input logic [15:0] a);
      return {8'hB0 + 8'(n), 8'h00, a};
   endfunction

   function automatic void push_gnt(input logic [1:0] g, input int gap);
      exp_t e;
      e.kind = K_GNT; e.a = {30'd0, g}; e.b = '0; e.c = gap;
      exp_q.push_back(e);
   endfunction

   function automatic void push_ack(input int n, input logic [15:0] adr, input logic [31:0] wd);
      exp_t e;
      e.kind = K_ACK; e.a = (n == 0) ? 32'd1 : 32'd2; e.b = {16'hD00D, adr}; e.c = int'(wd);
      exp_q.push_back(e);
   endfunction

   function automatic void push_err(input int n, input int stalls);
      exp_t e;
      e.kind = K_ERR; e.a = (n == 0) ? 32'd1 : 32'd2; e.b = '0; e.c = stalls;
      exp_q.push_back(e);
   endfunction

   // Zero-wait slave: acks every strobe except to the stall address; returns an address-tagged word
   initial begin
      s_ack_i = 1'b0;
      s_dat_i = '0;
      forever begin
         @(posedge clk);
         #2;
         s_ack_i = force_ack | (s_stb_o && (s_adr_o != STALL_ADR));
         s_dat_i = {16'hD00D, s_adr_o};
      end
   end

   // Monitor: every grant change, ack and err pops one expected event
   task automatic take_event(input int kind, input logic [31:0] a, input logic [31:0] b, input int c);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d a=%h at %0t, expected none", kind, a, $time);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 32'(kind), 32'(e.kind));
         chk("event_who", a, e.a);
         if (kind == K_ACK) begin
            chk("ack_rdata", b, e.b);
            chk("ack_wdata", 32'(c), 32'(e.c));
         end else if (kind == K_ERR) begin
            chk("err_bus_ctl", b, e.b);
            chk("err_stall_cycles", 32'(c), 32'(e.c));
         end else if (e.c >= 0) begin
            chk("grant_gap", 32'(c), 32'(e.c));
         end
      end
   endtask

   initial begin
      logic [1:0] prev_grant;
      int idle_run;
      int stall_run;
      prev_grant = 2'b00;
      idle_run = 0;
      stall_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_grant = 2'b00;
            idle_run = 0;
            stall_run = 0;
         end else begin
            if (grant_o != 2'b00 && grant_o != prev_grant)
               take_event(K_GNT, {30'd0, grant_o}, '0, idle_run);
            if (m0_err_o | m1_err_o)
               take_event(K_ERR, {30'd0, m1_err_o, m0_err_o}, {30'd0, s_cyc_o, s_stb_o}, stall_run);
            if (m0_ack_o | m1_ack_o)
               take_event(K_ACK, {30'd0, m1_ack_o, m0_ack_o}, m1_ack_o ? m1_dat_o : m0_dat_o, int'(s_dat_o));
            idle_run   = (grant_o == 2'b00) ? idle_run + 1 : 0;
            stall_run  = (s_stb_o && !s_ack_i) ? stall_run + 1 : 0;
            prev_grant = grant_o;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_master(input int n, input logic on, input logic [15:0] adr);
      if (n == 0) begin
         m0_cyc = on; m0_stb = on; m0_we = 1'b1; m0_sel = 4'hF; m0_adr = adr; m0_dat = wdat(0, adr);
      end else begin
         m1_cyc = on; m1_stb = on; m1_we = 1'b1; m1_sel = 4'hF; m1_adr = adr; m1_dat = wdat(1, adr);
      end
   endtask

   // Wishbone master: per job, nstb strobes in one cyc, stops on err, then one cycle with cyc low
   task automatic run_master(input int n, input int jobs, input int nstb, input logic [15:0] base);
      logic [15:0] adr;
      int  acks;
      int  waited;
      bit  done;
      bit  ack_s;
      bit  err_s;
      for (int j = 0; j < jobs; j++) begin
         adr = base + 16'(16 * j);
         acks = 0;
         waited = 0;
         done = 1'b0;
         drive_master(n, 1'b1, adr);
         while (!done) begin
            @(negedge clk);
            ack_s = (n == 0) ? m0_ack_o : m1_ack_o;
            err_s = (n == 0) ? m0_err_o : m1_err_o;
            if (ack_s) acks++;
            waited++;
            done = err_s || (acks == nstb) || (waited > 60);
            @(posedge clk);
            #1;
            if (done) drive_master(n, 1'b0, adr);
            else if (ack_s) drive_master(n, 1'b1, adr + 16'(4 * acks));
         end
         chk($sformatf("m%0d_job_budget", n), 32'(waited > 60), 32'd0);
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      force_ack = 1'b1;
      drive_master(0, 1'b1, 16'h1234);
      drive_master(1, 1'b1, 16'h5678);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", {30'd0, grant_o}, 32'd0);
      chk("rst_s_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
      chk("rst_s_we_sel", {27'd0, s_we_o, s_sel_o}, 32'd0);
      chk("rst_s_adr", {16'd0, s_adr_o}, 32'd0);
      chk("rst_s_dat", s_dat_o, 32'd0);
      chk("rst_ack_err", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
      drive_master(0, 1'b0, 16'h0);
      drive_master(1, 1'b0, 16'h0);
      force_ack = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Strobe without cyc is ignored
      m1_stb = 1'b1;
      tick();
      chk("stb_only_s_stb", {31'd0, s_stb_o}, 32'd0);
      tick();
      chk("stb_only_grant", {30'd0, grant_o}, 32'd0);
      m1_stb = 1'b0;

      // Late ack in IDLE must be dropped (monitor flags any ack)
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      tick();

      // Lone request with grant latency
      push_gnt(2'b01, -1);
      push_ack(0, 16'h0004, 32'h0000_00A5);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF; m0_adr = 16'h0004; m0_dat = 32'h0000_00A5;
      #1;
      chk("lone_cyc_same_cycle", {31'd0, s_cyc_o}, 32'd0);
      tick();
      chk("lone_cyc_next_cycle", {31'd0, s_cyc_o}, 32'd1);
      chk("lone_adr", {16'd0, s_adr_o}, 32'h0000_0004);
      chk("lone_dat", s_dat_o, 32'h0000_00A5);
      chk("lone_we", {31'd0, s_we_o}, 32'd1);
      tick();
      m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      chk("lone_release_cyc", {31'd0, s_cyc_o}, 32'd0);
      repeat (2) tick();

      // Asynchronous reset during a stalled tenure
      push_gnt(2'b01, -1);
      drive_master(0, 1'b1, STALL_ADR);
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_s_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
      chk("areset_grant", {30'd0, grant_o}, 32'd0);
      chk("areset_ack_err", {30'd0, m0_ack_o, m0_err_o}, 32'd0);
      drive_master(0, 1'b0, 16'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Simultaneous request after reset: m0 first, then m1 after one dead cycle
      push_gnt(2'b01, -1);
      push_ack(0, 16'h0010, wdat(0, 16'h0010));
      push_gnt(2'b10, 1);
      push_ack(1, 16'h0020, wdat(1, 16'h0020));
      fork
         run_master(0, 1, 1, 16'h0010);
         run_master(1, 1, 1, 16'h0020);
      join
      repeat (2) tick();

      // Fairness: six alternating tenures
      for (int k = 0; k < 3; k++) begin
         push_gnt(2'b01, (k == 0) ? -1 : 1);
         push_ack(0, 16'h0040 + 16'(16 * k), wdat(0, 16'h0040 + 16'(16 * k)));
         push_gnt(2'b10, 1);
         push_ack(1, 16'h0080 + 16'(16 * k), wdat(1, 16'h0080 + 16'(16 * k)));
      end
      fork
         run_master(0, 3, 1, 16'h0040);
         run_master(1, 3, 1, 16'h0080);
      join
      repeat (2) tick();

      // Locked burst: m1 keeps the bus for 4 strobes while m0 waits
      push_gnt(2'b10, -1);
      for (int k = 0; k < 4; k++)
         push_ack(1, 16'h0300 + 16'(4 * k), wdat(1, 16'h0300 + 16'(4 * k)));
      push_gnt(2'b01, 1);
      push_ack(0, 16'h0400, wdat(0, 16'h0400));
      fork
         run_master(1, 1, 4, 16'h0300);
         begin
            repeat (2) tick();
            run_master(0, 1, 1, 16'h0400);
         end
      join
      repeat (2) tick();

      // Watchdog: m0 stalls, err on the 8th stalled cycle, m1 then served
      push_gnt(2'b01, -1);
      push_err(0, 7);
      push_gnt(2'b10, 1);
      push_ack(1, 16'h0500, wdat(1, 16'h0500));
      fork
         run_master(0, 1, 1, STALL_ADR);
         begin
            tick();
            run_master(1, 1, 1, 16'h0500);
         end
      join
      repeat (5) tick();

      chk("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
